// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU data-bus memory responder.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        RESP = 2'd3
    } mem_state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_1000;
    localparam logic [31:0] OOR_READ_VALUE    = 32'hDEAD_BEEF;
    localparam int          BYTE_LANES        = 4;
    localparam int          WAIT_CNT_W        = 4;

endpackage

// File: rtl/mem_byte_ram.sv
// Single-port word RAM with per-lane write enables and a registered read port.
module mem_byte_ram
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  rd_en,
    input  logic [BYTE_LANES-1:0] wr_be,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < BYTE_LANES; lane++) begin
            if (wr_be[lane]) begin
                mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-bus responder: wait-state handshake, address decode and RAM access.
//
// state | meaning
// IDLE  | waiting for read xor write; read&write flags err and drops waitrequest once
// WAIT  | counting down programmed wait states with waitrequest high
// ACK   | waitrequest low; write commits or read samples RAM on this edge
// RESP  | readdatavalid high with the sampled word
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        err
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    mem_state_t                state;
    logic [WAIT_CNT_W-1:0]     wait_cnt;
    logic [31:0]               addr_q;
    logic [BYTE_LANES-1:0]     be_q;
    logic [31:0]               wdata_q;
    logic                      is_write_q;
    logic                      rd_oor_q;

    logic [31:0]               offset;
    logic                      in_range;
    logic [ADDR_WIDTH-1:0]     ram_idx;
    logic                      ram_rd_en;
    logic [BYTE_LANES-1:0]     ram_wr_be;
    logic [31:0]               ram_q;

    // Unsigned wrap below BASE_ADDR lands far above the window, so one compare covers both ends.
    always_comb begin
        offset   = addr_q - BASE_ADDR;
        in_range = ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
        ram_idx  = offset[ADDR_WIDTH+1:2];
    end

    always_comb begin
        ram_rd_en = 1'b0;
        ram_wr_be = '0;
        if (state == ACK && in_range) begin
            ram_rd_en = !is_write_q;
            ram_wr_be = is_write_q ? be_q : '0;
        end
    end

    mem_byte_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset),
        .addr  (ram_idx),
        .rd_en (ram_rd_en),
        .wr_be (ram_wr_be),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

    assign readdata = rd_oor_q ? OOR_READ_VALUE : ram_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            waitrequest   <= 1'b1;
            readdatavalid <= 1'b0;
            err           <= 1'b0;
            wait_cnt      <= '0;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            is_write_q    <= 1'b0;
            rd_oor_q      <= 1'b0;
        end else begin
            readdatavalid <= 1'b0;
            case (state)
                IDLE: begin
                    // A low waitrequest here is the retire cycle of an illegal request; ignore the bus once.
                    if (!waitrequest) begin
                        waitrequest <= 1'b1;
                    end else if (read && write) begin
                        err         <= 1'b1;
                        waitrequest <= 1'b0;
                    end else if (read || write) begin
                        addr_q     <= address;
                        be_q       <= byteenable;
                        wdata_q    <= writedata;
                        is_write_q <= write;
                        wait_cnt   <= WAIT_LOAD;
                        if (WAIT_CYCLES == 0) begin
                            state       <= ACK;
                            waitrequest <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == WAIT_CNT_W'(1)) begin
                        state       <= ACK;
                        waitrequest <= 1'b0;
                    end
                end
                ACK: begin
                    waitrequest <= 1'b1;
                    if (!in_range) begin
                        err <= 1'b1;
                    end
                    if (is_write_q) begin
                        state <= IDLE;
                    end else begin
                        state         <= RESP;
                        readdatavalid <= 1'b1;
                        rd_oor_q      <= !in_range;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    waitrequest <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances with 0, 1 and 3 wait states checked against a word-array model.
module tb_data_mem_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 1024;
    localparam int          WIN   = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [3];
    logic        read_s     [3];
    logic        write_s    [3];
    logic [31:0] addr_s     [3];
    logic [3:0]  be_s       [3];
    logic [31:0] wd_s       [3];
    logic        waitreq_w  [3];
    logic [31:0] rdata_w    [3];
    logic        rdv_w      [3];
    logic        err_w      [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .ADDR_WIDTH  (10),
            .BASE_ADDR   (BASE),
            .WAIT_CYCLES (g == 0 ? 0 : (g == 1 ? 1 : 3))
        ) u_dut (
            .clk           (clk),
            .reset         (rst_n[g]),
            .address       (addr_s[g]),
            .read          (read_s[g]),
            .write         (write_s[g]),
            .byteenable    (be_s[g]),
            .writedata     (wd_s[g]),
            .waitrequest   (waitreq_w[g]),
            .readdata      (rdata_w[g]),
            .readdatavalid (rdv_w[g]),
            .err           (err_w[g])
        );
    end

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem_m [3][DEPTH];
    bit          vld_m [3][DEPTH];
    bit          err_m [3];

    function automatic int wc(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        longint off;
        off = longint'({32'd0, a}) - longint'({32'd0, BASE});
        return (off >= 0) && (off < 4 * DEPTH);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request and records handshake timing relative to the sampling edge.
    task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd, input bit early,
                          output logic [31:0] got, output int first_low, output int n_low,
                          output int rdv_at, output int n_rdv, output logic wr_at2);
        @(negedge clk);
        read_s[d]  = rd;
        write_s[d] = wr;
        addr_s[d]  = a;
        be_s[d]    = be;
        wd_s[d]    = wd;
        got        = 'x;
        first_low  = 0;
        n_low      = 0;
        rdv_at     = 0;
        n_rdv      = 0;
        wr_at2     = 1'bx;
        for (int c = 1; c <= WIN; c++) begin
            @(negedge clk);
            if (!waitreq_w[d]) begin
                n_low++;
                if (first_low == 0) first_low = c;
            end
            if (rdv_w[d]) begin
                n_rdv++;
                rdv_at = c;
                got    = rdata_w[d];
            end
            if (c == 2) wr_at2 = waitreq_w[d];
            if ((early && c == 1) || (first_low != 0 && c == first_low + 1)) begin
                read_s[d]  = 1'b0;
                write_s[d] = 1'b0;
            end
        end
    endtask

    task automatic do_write(input int d, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] wd, input bit early);
        logic [31:0] got;
        logic        w2;
        int          fl, nl, ra, nr;
        logic [31:0] w;
        access(d, 1'b0, 1'b1, a, be, wd, early, got, fl, nl, ra, nr, w2);
        chk($sformatf("wr_accept_cycle d%0d", d), 32'(fl), 32'(wc(d) + 1));
        chk($sformatf("wr_low_count d%0d", d), 32'(nl), 32'd1);
        chk($sformatf("wr_no_rdv d%0d", d), 32'(nr), 32'd0);
        if (in_rng(a)) begin
            w = mem_m[d][idx_of(a)];
            for (int l = 0; l < 4; l++) begin
                if (be[l]) w[8*l +: 8] = wd[8*l +: 8];
            end
            mem_m[d][idx_of(a)] = w;
            if (be == 4'hF) vld_m[d][idx_of(a)] = 1'b1;
        end else begin
            err_m[d] = 1'b1;
        end
        chk($sformatf("wr_err d%0d", d), 32'(err_w[d]), 32'(err_m[d]));
    endtask

    task automatic do_read(input int d, input logic [31:0] a, input bit early, output logic [31:0] got);
        logic        w2;
        int          fl, nl, ra, nr;
        logic [31:0] exp;
        access(d, 1'b1, 1'b0, a, 4'h0, 32'h0, early, got, fl, nl, ra, nr, w2);
        chk($sformatf("rd_accept_cycle d%0d", d), 32'(fl), 32'(wc(d) + 1));
        chk($sformatf("rd_low_count d%0d", d), 32'(nl), 32'd1);
        chk($sformatf("rd_valid_cycle d%0d", d), 32'(ra), 32'(wc(d) + 2));
        chk($sformatf("rd_valid_count d%0d", d), 32'(nr), 32'd1);
        if (!in_rng(a)) begin
            err_m[d] = 1'b1;
            chk($sformatf("rd_oor_data d%0d a=%h", d, a), got, 32'hDEAD_BEEF);
        end else if (vld_m[d][idx_of(a)]) begin
            exp = mem_m[d][idx_of(a)];
            chk($sformatf("rd_data d%0d a=%h", d, a), got, exp);
        end
        chk($sformatf("rd_data_hold d%0d", d), rdata_w[d], got);
        chk($sformatf("rd_err d%0d", d), 32'(err_w[d]), 32'(err_m[d]));
    endtask

    initial begin
        logic [31:0] got, a, wd;
        logic [3:0]  be;
        logic        w2;
        int          fl, nl, ra, nr;

        for (int d = 0; d < 3; d++) begin
            rst_n[d]   = 1'b0;
            read_s[d]  = 1'b0;
            write_s[d] = 1'b0;
            addr_s[d]  = '0;
            be_s[d]    = '0;
            wd_s[d]    = '0;
            err_m[d]   = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                vld_m[d][i] = 1'b0;
                mem_m[d][i] = '0;
            end
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_waitreq d%0d", d), 32'(waitreq_w[d]), 32'd1);
            chk($sformatf("reset_rdata d%0d", d), rdata_w[d], 32'd0);
            chk($sformatf("reset_rdv d%0d", d), 32'(rdv_w[d]), 32'd0);
            chk($sformatf("reset_err d%0d", d), 32'(err_w[d]), 32'd0);
            rst_n[d] = 1'b1;
        end

        // Fill the 16-word working set on every instance so later reads are fully known.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) begin
                do_write(d, BASE + 32'(4 * i), 4'hF, $urandom, 1'b0);
            end
        end

        do_write(1, 32'h0000_1000, 4'hF, 32'h1122_3344, 1'b0);
        do_read(1, 32'h0000_1000, 1'b0, got);
        chk("first_read", got, 32'h1122_3344);
        do_write(1, 32'h0000_1000, 4'b0101, 32'hAABB_CCDD, 1'b0);
        do_read(1, 32'h0000_1000, 1'b0, got);
        chk("merged_read", got, 32'h11BB_33DD);

        do_write(1, 32'h0000_1004, 4'hF, 32'h5555_AAAA, 1'b0);
        access(1, 1'b1, 1'b1, 32'h0000_1004, 4'hF, 32'h0BAD_0BAD, 1'b0, got, fl, nl, ra, nr, w2);
        err_m[1] = 1'b1;
        chk("illegal_low_cycle", 32'(fl), 32'd1);
        chk("illegal_low_count", 32'(nl), 32'd1);
        chk("illegal_no_rdv", 32'(nr), 32'd0);
        chk("illegal_idle_next", 32'(w2), 32'd1);
        chk("illegal_err", 32'(err_w[1]), 32'd1);
        do_read(1, 32'h0000_1004, 1'b0, got);
        chk("illegal_ram_kept", got, 32'h5555_AAAA);

        do_read(1, 32'h0000_0FFC, 1'b0, got);
        do_read(1, BASE + 32'(4 * DEPTH), 1'b0, got);
        do_write(1, 32'h0000_0FFC, 4'hF, 32'hFFFF_0000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            do_read(1, BASE + 32'(4 * i), 1'b0, got);
        end
        chk("err_sticky", 32'(err_w[1]), 32'd1);

        do_write(1, 32'h0000_1008, 4'hF, 32'h0102_0304, 1'b0);
        @(negedge clk);
        write_s[1] = 1'b1;
        addr_s[1]  = 32'h0000_1008;
        be_s[1]    = 4'hF;
        wd_s[1]    = 32'hFFFF_FFFF;
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        chk("midreset_waitreq", 32'(waitreq_w[1]), 32'd1);
        chk("midreset_rdata", rdata_w[1], 32'd0);
        chk("midreset_rdv", 32'(rdv_w[1]), 32'd0);
        chk("midreset_err", 32'(err_w[1]), 32'd0);
        write_s[1] = 1'b0;
        err_m[1]   = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        do_read(1, 32'h0000_1008, 1'b0, got);
        chk("midreset_write_dropped", got, 32'h0102_0304);

        for (int n = 0; n < 60; n++) begin
            for (int d = 0; d < 3; d++) begin
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       a = BASE - 32'd4;
                        1:       a = BASE + 32'(4 * DEPTH);
                        2:       a = 32'hFFFF_FFFC;
                        default: a = 32'h0000_0000;
                    endcase
                end else begin
                    a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
                end
                be = 4'($urandom_range(0, 15));
                wd = $urandom;
                if ($urandom_range(0, 1) == 0) begin
                    do_write(d, a, be, wd, $urandom_range(0, 3) == 0);
                end else begin
                    do_read(d, a, $urandom_range(0, 3) == 0, got);
                end
            end
        end

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) begin
                do_read(d, BASE + 32'(4 * i), 1'b0, got);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
